// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU opcode constants and the BCD converter state encoding.
package calc_pkg;

    localparam logic [10:0] OP_ADD = 11'h001;
    localparam logic [10:0] OP_SUB = 11'h002;
    localparam logic [10:0] OP_MUL = 11'h004;
    localparam logic [10:0] OP_DIV = 11'h008;

    localparam int unsigned RESULT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/alu_result_bcd.sv
// Sequential double-dabble converter turning the 8-bit ALU result into three BCD digits,
// with remainder display and leading-zero blanking for the divide operation.
module alu_result_bcd
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  result,
    input  logic [2:0]  rem,
    input  logic [10:0] op_code,
    output logic        busy,
    output logic        done,
    output logic [3:0]  hund,
    output logic [3:0]  tens,
    output logic [3:0]  ones,
    output logic [3:0]  rem_digit,
    output logic        show_rem,
    output logic [1:0]  blank
);

    conv_state_e state_q, state_d;
    logic [11:0] bcd_q, bcd_d;
    logic [11:0] bcd_adj;
    logic [7:0]  opnd_q, opnd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  rem_q, rem_d;
    logic [10:0] op_q, op_d;
    logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic [3:0]  remd_q, remd_d;
    logic        show_q, show_d;
    logic [1:0]  blank_q, blank_d;
    logic        done_q, done_d;

    for (genvar g = 0; g < 3; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (bcd_q[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            remd_q  <= '0;
            show_q  <= 1'b0;
            blank_q <= 2'b11;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            remd_q  <= remd_d;
            show_q  <= show_d;
            blank_q <= blank_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        op_d    = op_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        remd_d  = remd_q;
        show_d  = show_q;
        blank_d = blank_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d  = result;
                    rem_d   = rem;
                    op_d    = op_code;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The 3-bit count wraps to zero on the 8th shift, so 7 marks the last one.
                {bcd_d, opnd_d} = {bcd_adj, opnd_q} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hund_d  = bcd_q[11:8];
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                show_d  = (op_q == OP_DIV) && (rem_q != 3'd0);
                remd_d  = show_d ? {1'b0, rem_q} : 4'd0;
                blank_d = {bcd_q[11:8] == 4'd0, bcd_q[11:4] == 8'd0};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign hund      = hund_q;
    assign tens      = tens_q;
    assign ones      = ones_q;
    assign rem_digit = remd_q;
    assign show_rem  = show_q;
    assign blank     = blank_q;

endmodule

// File: doc/alu_result_bcd.md
ALU_RESULT_BCD -- requirements
Module: alu_result_bcd

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request to convert the current ALU result; sampled only in IDLE.
REQ-004 The block SHALL have the port result, input, 8 bits: unsigned ALU quotient, sum, difference or product.
REQ-005 The block SHALL have the port rem, input, 3 bits: ALU division remainder.
REQ-006 The block SHALL have the port op_code, input, 11 bits: one-hot ALU operation (001h add, 002h sub, 004h mul, 008h div).
REQ-007 The block SHALL have the port busy, output, 1 bit: high in the SHIFT and DONE states.
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse when the digit outputs update.
REQ-009 The block SHALL have the ports hund, tens and ones, outputs, 4 bits each: BCD digits of result.
REQ-010 The block SHALL have the port rem_digit, output, 4 bits: BCD remainder (0-7).
REQ-011 The block SHALL have the port show_rem, output, 1 bit: display the remainder field.
REQ-012 The block SHALL have the port blank, output, 2 bits: [1] blanks hund and [0] blanks tens for leading-zero suppression.

Function
REQ-013 The block SHALL use the states IDLE, SHIFT and DONE, with sequential double-dabble conversion of 8 bits.
REQ-014 On start=1 in IDLE at edge k, the block SHALL latch result, rem and op_code, clear a 12-bit BCD scratch and a 3-bit count, and enter SHIFT.
REQ-015 In SHIFT, on each edge, the block SHALL add 3 to every scratch nibble that is 5 or greater, then shift {scratch, operand} left by 1, and increment count.
REQ-016 After the 8th shift (edge k+8), the block SHALL enter DONE.
REQ-017 At edge k+9 (DONE to IDLE), the block SHALL register hund, tens, ones, rem_digit, show_rem and blank, and assert done for exactly that cycle.
REQ-018 The total latency SHALL be 9 cycles from the start-sampling edge to the done-rising edge; throughput SHALL be one conversion per 10 cycles.
REQ-019 show_rem SHALL be 1 if and only if the latched op_code equals 008h and the latched rem is not 0.
REQ-020 rem_digit SHALL be {1'b0, latched rem} when show_rem=1, and 0 otherwise.
REQ-021 blank[1] SHALL be 1 when hund=0; blank[0] SHALL be 1 when hund=0 and tens=0; ones SHALL never be blanked.
REQ-022 start while busy (SHIFT or DONE) SHALL be ignored and not queued; start in the cycle after done SHALL be accepted.
REQ-023 Changes to the input ports after the start-sampling edge SHALL NOT affect the conversion in progress.
REQ-024 Digit outputs SHALL hold their last values until the next done; they SHALL never show intermediate scratch values.
REQ-025 A non-one-hot or zero op_code SHALL still convert result, with show_rem=0.

Reset
REQ-026 When rst_n=0, the block SHALL immediately force IDLE, busy=0, done=0, hund=tens=ones=0, rem_digit=0, show_rem=0, blank=2'b11, and clear the scratch and count.
REQ-027 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse; the first start after rst_n rises SHALL be handled normally.

Structure
REQ-028 The shared package calc_pkg SHALL hold the opcode constants OP_ADD, OP_SUB, OP_MUL and OP_DIV and the state encoding, and the ALU SHALL reuse these opcode constants.
REQ-029 The block SHALL instantiate one sub-module, bcd_add3 (4-bit nibble: if 5 or greater, add 3), three times for the scratch nibbles.

Verification
REQ-030 The bench SHALL cover: result=255, op=001h, start -> done 9 cycles later; digits 2,5,5; blank=00; show_rem=0.
REQ-031 The bench SHALL cover: result=0, op=004h -> digits 0,0,0; blank=11.
REQ-032 The bench SHALL cover: result=3, rem=1, op=008h (7/2) -> ones=3; blank=11; show_rem=1; rem_digit=1.
REQ-033 The bench SHALL cover: result=42; start pulsed again 3 cycles later with result=99 -> a single done; digits 0,4,2; blank=10.
REQ-034 The bench SHALL cover: rst_n low for 1 cycle at cycle 4 of a conversion of 200 -> no done; outputs at reset values; a new start with 7 -> 0,0,7 after 9 cycles.
REQ-035 The bench SHALL cover: back-to-back start asserted every cycle with 128 -> done every 10 cycles; digits 1,2,8.
